// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed common-anode 4-digit hex display driver
//
// Purpose: shows a 16-bit value as four hex digits on a common-anode
// seven-segment display. The digits are time-multiplexed by a built-in
// prescaler. New values are latched into a shadow register. They reach the
// display only at a frame boundary, so a frame never mixes two values.
// Guard cycles at the start of each slot keep all anodes off to avoid ghosting.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   arst       - synchronous active-high reset
//   load       - one-cycle strobe, captures value into the shadow register
//   value      - four hex nibbles, digit 3 = value[15:12], digit 0 = value[3:0]
//   blank_lz   - leading-zero blanking enable, sampled every cycle
//   an         - anode enables, active-low, an[i] drives digit i
//   seg        - segments {g,f,e,d,c,b,a}, active-low
//   frame_done - one-cycle pulse after each frame wrap
module seg7_scan_driver #(
   parameter int DIV   = 100000,
   parameter int GUARD = 4
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        load,
   input  logic [15:0] value,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        frame_done
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] GUARD_CNT = PW'(GUARD);

   logic [PW-1:0] pcnt;
   logic [1:0]    idx;
   logic [15:0]   shadow;
   logic [15:0]   disp;
   logic          pending;

   logic          slot_end;
   logic          frame_wrap;
   logic [3:0]    nib;
   logic          zero3;
   logic          zero2;
   logic          zero1;
   logic          digit_blank;
   logic          in_guard;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_comb begin
      slot_end   = (pcnt == PCNT_LAST);
      frame_wrap = slot_end && (idx == 2'd3);
      nib        = disp[{idx, 2'b00} +: 4];
      in_guard   = (pcnt < GUARD_CNT);

      // A digit is a leading zero when it and every more-significant digit are zero.
      zero3 = (disp[15:12] == 4'h0);
      zero2 = zero3 && (disp[11:8] == 4'h0);
      zero1 = zero2 && (disp[7:4] == 4'h0);

      digit_blank = 1'b0;
      case (idx)
         2'd3:    digit_blank = blank_lz && zero3;
         2'd2:    digit_blank = blank_lz && zero2;
         2'd1:    digit_blank = blank_lz && zero1;
         default: digit_blank = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         pcnt       <= '0;
         idx        <= 2'd0;
         shadow     <= 16'h0000;
         disp       <= 16'h0000;
         pending    <= 1'b0;
         an         <= 4'b1111;
         seg        <= 7'b1111111;
         frame_done <= 1'b0;
      end else begin
         pcnt <= slot_end ? '0 : pcnt + 1'b1;
         if (slot_end) begin
            idx <= idx + 2'd1;
         end

         // The wrap copies the shadow as it stood before this edge. A load on
         // the same edge stays pending for the following frame.
         if (frame_wrap && pending) begin
            disp <= shadow;
         end
         if (load) begin
            shadow <= value;
         end
         pending <= load || (pending && !frame_wrap);

         an         <= in_guard ? 4'b1111 : ~(4'b0001 << idx);
         seg        <= digit_blank ? 7'b1111111 : hex_to_seg(nib);
         frame_done <= frame_wrap;
      end
   end

endmodule
